// File: rtl/seq_match_pkg.sv
// Shared constants and helpers for the seq_match_engine temporal-pattern monitor.
package seq_match_pkg;

  localparam int DE_MIN_DEF = 2;
  localparam int DE_MAX_DEF = 5;
  localparam int CNT_W_DEF  = 8;
  localparam int HIST_MAX   = 16;

  // Increment v unless it already holds the largest value representable in w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_window_tracker.sv
// d-to-e window tracker: d history plus pending-attempt vector, with combinational
// hit and timeout outputs for the sample currently on d/e.
module seq_window_tracker
  import seq_match_pkg::*;
#(
  parameter int DE_MIN = DE_MIN_DEF,
  parameter int DE_MAX = DE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic e,
  output logic win_hit,
  output logic win_timeout
);

  if (DE_MIN < 1 || DE_MIN > DE_MAX || DE_MAX > HIST_MAX) begin : g_param_check
    $error("seq_window_tracker: illegal DE_MIN/DE_MAX combination");
  end

  // Bit k holds the state of the d sampled k cycles ago.
  logic [DE_MAX:1] dh_q, dh_d;
  logic [DE_MAX:1] pd_q, pd_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_hit = 1'b0;
    for (int k = DE_MIN; k <= DE_MAX; k++) begin
      win_hit = win_hit | (e & dh_q[k]);
    end
    win_timeout = pd_q[DE_MAX] & ~e;

    dh_d    = '0;
    pd_d    = '0;
    dh_d[1] = d;
    pd_d[1] = d;
    // e retires only attempts already inside the window; a same-cycle d starts fresh.
    for (int k = 2; k <= DE_MAX; k++) begin
      dh_d[k] = dh_q[k-1];
      pd_d[k] = pd_q[k-1] & ~(e & ((k - 1) >= DE_MIN));
    end
  end

  // NOTE: the history is reset too, so attempts in flight at reset can never hit or time out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dh_q <= '0;
      pd_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      dh_q <= dh_d;
      pd_q <= pd_d;
    end
  end

endmodule

// File: rtl/seq_match_engine.sv
// Monitors the abc and de temporal patterns, producing registered pulses and
// saturating hit counters.
module seq_match_engine
  import seq_match_pkg::*;
#(
  parameter int DE_MIN = DE_MIN_DEF,
  parameter int DE_MAX = DE_MAX_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             clr,
  output logic             abc_hit,
  output logic             de_hit,
  output logic             de_timeout,
  output logic [CNT_W-1:0] abc_cnt,
  output logic [CNT_W-1:0] de_cnt
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_param_check
    $error("seq_match_engine: CNT_W must be in 1..32");
  end

  logic             s1_q, s2_q;
  logic             abc_hit_q, de_hit_q, de_timeout_q;
  logic [CNT_W-1:0] abc_cnt_q, abc_cnt_d, de_cnt_q, de_cnt_d;
  logic             abc_match, win_hit, win_timeout;

  seq_window_tracker #(
    .DE_MIN (DE_MIN),
    .DE_MAX (DE_MAX)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .e           (e),
    .win_hit     (win_hit),
    .win_timeout (win_timeout)
  );

  assign abc_match = s2_q & c;

  // Counters advance on the same edge that raises the pulse; clr has priority.
  always_comb begin
    abc_cnt_d = abc_cnt_q;
    de_cnt_d  = de_cnt_q;
    if (clr) begin
      abc_cnt_d = '0;
      de_cnt_d  = '0;
    end else begin
      if (abc_match) abc_cnt_d = CNT_W'(sat_inc(32'(abc_cnt_q), CNT_W));
      if (win_hit)   de_cnt_d  = CNT_W'(sat_inc(32'(de_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      abc_hit_q    <= 1'b0;
      de_hit_q     <= 1'b0;
      de_timeout_q <= 1'b0;
      abc_cnt_q    <= '0;
      de_cnt_q     <= '0;
    end else begin
      s1_q         <= a;
      s2_q         <= s1_q & b;
      abc_hit_q    <= abc_match;
      de_hit_q     <= win_hit;
      de_timeout_q <= win_timeout;
      abc_cnt_q    <= abc_cnt_d;
      de_cnt_q     <= de_cnt_d;
    end
  end

  assign abc_hit    = abc_hit_q;
  assign de_hit     = de_hit_q;
  assign de_timeout = de_timeout_q;
  assign abc_cnt    = abc_cnt_q;
  assign de_cnt     = de_cnt_q;

endmodule
